// File: rtl/water_inlet_arbiter.sv
// water_inlet_arbiter
//   Shares one mains inlet valve between N_MACHINES washer controllers.
//   Grants are round-robin, one machine at a time. Each grant is followed by
//   an inlet-closed pressure-settle gap. A per-grant fill watchdog sets a
//   sticky fault on a machine whose fill never completes, and a faulted
//   machine is locked out until its fault is cleared.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   fill_req        per-machine level request (the machine's fill_valve_on)
//   fault_clr       per-machine one-cycle pulse, clears that machine's fault
//   grant           registered one-hot (or zero) inlet grant
//   grant_id        index of the granted machine, 0 when the inlet is closed
//   inlet_valve_on  registered mains inlet enable (== |grant)
//   fill_fault      registered sticky fill-timeout flags
//   busy            high while a grant or settle period is in progress

// One sticky fault bit per machine. A set on the same edge as a clear wins.
module water_inlet_fault_cell (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic fault
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      fault <= 1'b0;
    else if (set) fault <= 1'b1;
    else if (clr) fault <= 1'b0;
  end
endmodule

module water_inlet_arbiter #(
  parameter int N_MACHINES      = 4,
  parameter int MAX_FILL_CYCLES = 1000,
  parameter int SETTLE_CYCLES   = 4,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_MACHINES-1:0] fill_req,
  input  logic [N_MACHINES-1:0] fault_clr,
  output logic [N_MACHINES-1:0] grant,
  output logic [2:0]            grant_id,
  output logic                  inlet_valve_on,
  output logic [N_MACHINES-1:0] fill_fault,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, GRANT, SETTLE} state_t;

  localparam logic [CNT_W-1:0] FILL_LAST   = CNT_W'(MAX_FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_MACHINES-1:0] ONE    = N_MACHINES'(1);

  state_t                  state;
  logic [2:0]              ptr;
  logic [CNT_W-1:0]        fill_cnt;
  logic [CNT_W-1:0]        settle_cnt;

  logic [N_MACHINES-1:0]   elig;
  logic [2*N_MACHINES-1:0] elig2;
  logic [N_MACHINES-1:0]   rot;
  logic                    sel_vld;
  logic [2:0]              sel_id;
  logic                    req_held;
  logic                    fill_timeout;
  logic [N_MACHINES-1:0]   fault_set;

  assign elig = fill_req & ~fill_fault;

  // Rotate the eligible set so bit 0 is the pointer position; the first set
  // bit of the rotated vector is the round-robin winner.
  assign elig2 = {elig, elig} >> ptr;
  assign rot   = elig2[N_MACHINES-1:0];

  always_comb begin
    int s;
    s       = 0;
    sel_vld = 1'b0;
    sel_id  = 3'd0;
    for (int k = 0; k < N_MACHINES; k++) begin
      if (!sel_vld && rot[k]) begin
        sel_vld = 1'b1;
        s = int'(ptr) + k;
        if (s >= N_MACHINES) s = s - N_MACHINES;
        sel_id = 3'(s);
      end
    end
  end

  // grant is one-hot, so masking avoids a variable index into fill_req.
  assign req_held     = |(fill_req & grant);
  assign fill_timeout = (state == GRANT) && req_held && (fill_cnt == FILL_LAST);
  assign fault_set    = fill_timeout ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= 3'd0;
      fill_cnt       <= '0;
      settle_cnt     <= '0;
      grant          <= '0;
      grant_id       <= 3'd0;
      inlet_valve_on <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            grant          <= ONE << sel_id;
            grant_id       <= sel_id;
            inlet_valve_on <= 1'b1;
            fill_cnt       <= '0;
            ptr            <= (sel_id == 3'(N_MACHINES - 1)) ? 3'd0 : sel_id + 3'd1;
            busy           <= 1'b1;
            state          <= GRANT;
          end
        end
        GRANT: begin
          // Normal release and timeout release close the inlet identically;
          // the timeout only differs by setting the fault bit (fault_set).
          if (!req_held || fill_cnt == FILL_LAST) begin
            grant          <= '0;
            grant_id       <= 3'd0;
            inlet_valve_on <= 1'b0;
            settle_cnt     <= SETTLE_LOAD;
            state          <= SETTLE;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: begin
          grant          <= '0;
          grant_id       <= 3'd0;
          inlet_valve_on <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N_MACHINES; i++) begin : g_fault
    water_inlet_fault_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .set   (fault_set[i]),
      .clr   (fault_clr[i]),
      .fault (fill_fault[i])
    );
  end

endmodule

// File: doc/water_inlet_arbiter.md
Name: water_inlet_arbiter

Overview:
- Shares one mains water inlet valve between N washing machine controllers in a multi-machine laundry installation.
- Each machine's fill_valve_on output becomes a fill request. The arbiter grants the inlet to exactly one machine at a time, using round-robin order.
- After each grant it inserts a pressure-settle gap before the next grant.
- It runs a per-grant fill watchdog that flags and locks out a machine whose fill never completes.

Parameters:
N_MACHINES, 4, number of requesting machines (2..8)
MAX_FILL_CYCLES, 1000, maximum cycles one grant may stay active before a fault
SETTLE_CYCLES, 4, inlet-closed settle period between grants (must be >=1)
CNT_W, 16, width of the fill/settle counters (must hold MAX_FILL_CYCLES)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
fill_req  in  N_MACHINES  per-machine fill request, level, held until filled
fault_clr  in  N_MACHINES  per-machine single-cycle pulse, clears sticky fault
grant  out  N_MACHINES  one-hot (or zero) inlet grant, registered
grant_id  out  3  index of granted machine, valid while inlet_valve_on=1, else 0
inlet_valve_on  out  1  mains inlet open; equals OR of grant, registered
fill_fault  out  N_MACHINES  sticky fill-timeout flag per machine, registered
busy  out  1  high in GRANT or SETTLE state

Behaviour:
- Reset (async) values:
  - grant=0, grant_id=0, inlet_valve_on=0, fill_fault=0, busy=0.
  - State=IDLE; round-robin pointer=0; counters=0.
  - Reset mid-grant closes the inlet immediately, without waiting for a clock edge.
- Eligible set: fill_req & ~fill_fault.
- Selection: the first eligible index, searching pointer, pointer+1, ... with wrap mod N_MACHINES.
- State machine, IDLE -> GRANT -> SETTLE -> IDLE:
  - IDLE: if the eligible set is non-zero at edge E:
    - At E, grant becomes the one-hot of the selected index, inlet_valve_on=1, grant_id=index, and fill_cnt=0.
    - pointer becomes (index+1) mod N_MACHINES; state=GRANT.
    - Grant latency from request is 1 cycle.
  - GRANT: checked at each edge, in this priority:
    1. fill_req[granted]=0: release. grant=0, inlet_valve_on=0, state=SETTLE, settle_cnt=SETTLE_CYCLES-1. No fault.
    2. fill_cnt==MAX_FILL_CYCLES-1: timeout release. Same as item 1, and also fill_fault[granted] is set.
    3. Otherwise fill_cnt increments.
  - Grant therefore stays high for at most exactly MAX_FILL_CYCLES cycles.
  - Requests from other machines are ignored during GRANT (no preemption).
  - SETTLE: settle_cnt decrements each edge; at the edge where settle_cnt==0, state=IDLE.
- Gap timing: the inlet stays closed for SETTLE_CYCLES+1 cycles minimum between consecutive grants (SETTLE cycles plus one IDLE evaluation cycle).
- Faults:
  - fault_clr[i] clears fill_fault[i] at the next edge.
  - If a set and a clear for the same bit land on the same edge, set wins.
  - fault_clr for the currently granted machine does not affect the grant.
  - A faulted machine is never granted.
  - A request from a faulted machine is held pending and becomes eligible the cycle after its fault clears.
- A request that drops and re-asserts during SETTLE is simply re-evaluated in IDLE.
- Invariants:
  - grant is zero or one-hot.
  - grant_id is consistent with grant.
  - inlet_valve_on == |grant.
  - busy == (state!=IDLE).

Test Plan:
1. Single machine: fill_req=4'b0001 from reset. Required: grant=0001 and inlet_valve_on=1 one cycle later. Drop req after 10 cycles: grant=0 next edge; busy low after 4 more cycles.
2. Simultaneous requests: fill_req=4'b0110 after reset. Required: machine 1 is granted first. After it releases, machine 2 is granted exactly SETTLE_CYCLES+1=5 cycles after grant fell.
3. Fairness: all 4 requests held and each released after 3 cycles of grant. Required grant order: 0,1,2,3,0,1. The pointer wraps correctly.
4. Timeout (MAX_FILL_CYCLES=20): req[2] held forever. Required:
   - grant[2] high for exactly 20 cycles, then fill_fault=0100.
   - Machine 2 is not granted again while its fault is set, and the other requesters proceed.
5. Fault clear: pulse fault_clr[2] on the same edge a new timeout sets fault[2]. Required: fault stays 1. A later pulse alone clears it, and machine 2 is regranted in round-robin order.
6. Reset mid-grant: assert rst asynchronously while grant=0001. Required: grant, inlet_valve_on, fill_fault and busy go to 0 immediately. After release, the first grant goes to machine 0 (pointer back to 0).
